// File: rtl/common.sv
// Shared memory-bus types for the core memory port arbiter and its helpers.
package common;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    logic    write;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    word_t data;
  } cbus_rsp_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (ibus) and memory-stage (dbus)
// requesters: dbus wins unless fetch is pending and has been starved.
module mem_arb_pick (
  input  logic ireq_valid,
  input  logic dreq_valid,
  input  logic starved,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = dreq_valid && !(ireq_valid && starved);
  assign grant_i = ireq_valid && !grant_d;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single core bus between ibus and dbus, one transaction in flight.
// Optional macro MEM_ARB_PERF_EN adds perf_icnt/perf_dcnt/perf_busy counters.
module mem_bus_arbiter
  import common::*;
#(
  parameter int MAX_STARVE = 4
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [63:0]       ireq_addr,
  output logic              iresp_ready,
  output logic [63:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [63:0]       dreq_addr,
  input  logic              dreq_write,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [63:0]       dreq_data,
  output logic              dresp_ready,
  output logic [63:0]       dresp_data,
  output logic              creq_valid,
  output logic [63:0]       creq_addr,
  output logic              creq_write,
  output logic [2:0]        creq_size,
  output logic [7:0]        creq_strobe,
  output logic [63:0]       creq_data,
  input  logic              cresp_ready,
  input  logic [63:0]       cresp_data
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_icnt,
  output logic [CNT_W-1:0]  perf_dcnt,
  output logic [CNT_W-1:0]  perf_busy
`endif
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;

  arb_state_t    r_state, w_state_next;
  cbus_req_t     r_req, w_req_next;
  cbus_rsp_t     w_rsp;
  logic [SW-1:0] r_starve, w_starve_next;
  logic          w_starved, w_grant_i, w_grant_d;

  assign w_rsp     = '{ready: cresp_ready, data: cresp_data};
  assign w_starved = (r_starve == SW'(MAX_STARVE));

  mem_arb_pick u_pick (
    .ireq_valid (ireq_valid),
    .dreq_valid (dreq_valid),
    .starved    (w_starved),
    .grant_i    (w_grant_i),
    .grant_d    (w_grant_d)
  );

  always_comb begin
    w_state_next  = r_state;
    w_req_next    = r_req;
    w_starve_next = r_starve;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_next = BUSY_D;
          w_req_next   = '{valid: 1'b1, addr: dreq_addr, write: dreq_write,
                           size: msize_t'(dreq_size),
                           strobe: dreq_write ? dreq_strobe : 8'h00,
                           data: dreq_data};
          if (ireq_valid && !w_starved) w_starve_next = r_starve + SW'(1);
        end else if (w_grant_i) begin
          w_state_next  = BUSY_I;
          w_req_next    = '{valid: 1'b1, addr: ireq_addr, write: 1'b0,
                            size: MSIZE4, strobe: 8'h00, data: 64'h0};
          w_starve_next = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_rsp.ready) begin
          w_state_next     = IDLE;
          w_req_next.valid = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_next;
      r_req    <= w_req_next;
      r_starve <= w_starve_next;
    end
  end

  assign creq_valid  = r_req.valid;
  assign creq_addr   = r_req.addr;
  assign creq_write  = r_req.write;
  assign creq_size   = r_req.size;
  assign creq_strobe = r_req.strobe;
  assign creq_data   = r_req.data;

  // A flushed fetch (ireq_valid dropped) still completes, but its data is discarded.
  assign iresp_ready = (r_state == BUSY_I) && w_rsp.ready && ireq_valid;
  assign iresp_data  = iresp_ready ? w_rsp.data : 64'h0;
  assign dresp_ready = (r_state == BUSY_D) && w_rsp.ready;
  assign dresp_data  = dresp_ready ? w_rsp.data : 64'h0;

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] r_icnt, r_dcnt, r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_icnt <= '0;
      r_dcnt <= '0;
      r_busy <= '0;
    end else begin
      if (r_state == BUSY_I && w_rsp.ready) r_icnt <= r_icnt + CNT_W'(1);
      if (r_state == BUSY_D && w_rsp.ready) r_dcnt <= r_dcnt + CNT_W'(1);
      if (r_state != IDLE)                  r_busy <= r_busy + CNT_W'(1);
    end
  end

  assign perf_icnt = r_icnt;
  assign perf_dcnt = r_dcnt;
  assign perf_busy = r_busy;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter; define MEM_ARB_PERF_EN to also check the counters.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = '0;
  logic        iresp_ready;
  logic [63:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = '0;
  logic        dreq_write = 1'b0;
  logic [2:0]  dreq_size = '0;
  logic [7:0]  dreq_strobe = '0;
  logic [63:0] dreq_data = '0;
  logic        dresp_ready;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic [63:0] creq_addr;
  logic        creq_write;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready = 1'b0;
  logic [63:0] cresp_data = '0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_icnt, perf_dcnt, perf_busy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_STARVE(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ireq_valid  (ireq_valid),
    .ireq_addr   (ireq_addr),
    .iresp_ready (iresp_ready),
    .iresp_data  (iresp_data),
    .dreq_valid  (dreq_valid),
    .dreq_addr   (dreq_addr),
    .dreq_write  (dreq_write),
    .dreq_size   (dreq_size),
    .dreq_strobe (dreq_strobe),
    .dreq_data   (dreq_data),
    .dresp_ready (dresp_ready),
    .dresp_data  (dresp_data),
    .creq_valid  (creq_valid),
    .creq_addr   (creq_addr),
    .creq_write  (creq_write),
    .creq_size   (creq_size),
    .creq_strobe (creq_strobe),
    .creq_data   (creq_data),
    .cresp_ready (cresp_ready),
    .cresp_data  (cresp_data)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_icnt   (perf_icnt),
    .perf_dcnt   (perf_dcnt),
    .perf_busy   (perf_busy)
`endif
  );

  // Inputs change right after the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(); tick();
    #1;
    n_tests++; if (creq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_creq_valid got=%b exp=0", creq_valid); end
    n_tests++; if (creq_addr !== 64'h0) begin n_fail++; $display("FAIL rst_creq_addr got=%h exp=0", creq_addr); end
    n_tests++; if (creq_size !== 3'd0) begin n_fail++; $display("FAIL rst_creq_size got=%0d exp=0", creq_size); end
    n_tests++; if (iresp_ready !== 1'b0 || dresp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_resp got=%b%b exp=00", iresp_ready, dresp_ready); end
    reset = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_fetch();
    int pulses = 0;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
    tick(); #1;
    n_tests++; if (creq_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_creq_valid got=%b exp=1", creq_valid); end
    n_tests++; if (creq_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL fetch_addr got=%h exp=0000000080000000", creq_addr); end
    n_tests++; if (creq_size !== 3'd2 || creq_write !== 1'b0 || creq_strobe !== 8'h00) begin n_fail++; $display("FAIL fetch_attr got size=%0d wr=%b strb=%h exp size=2 wr=0 strb=00", creq_size, creq_write, creq_strobe); end
    if (iresp_ready) pulses++;
    tick(); cresp_ready = 1'b1; cresp_data = 64'h13; #1;
    n_tests++; if (iresp_data !== 64'h13 || iresp_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_data got rdy=%b data=%h exp rdy=1 data=13", iresp_ready, iresp_data); end
    if (iresp_ready) pulses++;
    tick(); cresp_ready = 1'b0; ireq_valid = 1'b0; #1;
    if (iresp_ready) pulses++;
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL fetch_pulses got=%0d exp=1", pulses); end
    n_tests++; if (creq_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_done_valid got=%b exp=0", creq_valid); end
    $display("[TB] fetch 80000000 -> %h", 64'h13);
  endtask

  task automatic test_both_valid();
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
    dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_write = 1'b1;
    dreq_size = 3'd3; dreq_strobe = 8'hFF; dreq_data = 64'hDEAD_BEEF_CAFE_F00D;
    tick(); #1;
    n_tests++; if (creq_addr !== 64'h8000_1000 || creq_write !== 1'b1) begin n_fail++; $display("FAIL both_d_first got addr=%h wr=%b exp addr=0000000080001000 wr=1", creq_addr, creq_write); end
    n_tests++; if (creq_strobe !== 8'hFF || creq_size !== 3'd3 || creq_data !== 64'hDEAD_BEEF_CAFE_F00D) begin n_fail++; $display("FAIL both_d_payload got strb=%h size=%0d data=%h", creq_strobe, creq_size, creq_data); end
    // Requester changes are ignored after the grant.
    dreq_addr = 64'h1234; cresp_ready = 1'b1; cresp_data = 64'h0; #1;
    n_tests++; if (dresp_ready !== 1'b1 || iresp_ready !== 1'b0 || creq_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL both_d_resp got d=%b i=%b addr=%h exp d=1 i=0 addr=0000000080001000", dresp_ready, iresp_ready, creq_addr); end
    $display("[TB] store 80001000 strobe ff done");
    tick(); cresp_ready = 1'b0; dreq_valid = 1'b0; dreq_write = 1'b0; #1;
    n_tests++; if (creq_valid !== 1'b0) begin n_fail++; $display("FAIL both_idle_gap got=%b exp=0", creq_valid); end
    tick(); #1;
    n_tests++; if (creq_addr !== 64'h8000_0004 || creq_size !== 3'd2 || creq_write !== 1'b0 || creq_strobe !== 8'h00) begin n_fail++; $display("FAIL both_i_second got addr=%h size=%0d wr=%b strb=%h", creq_addr, creq_size, creq_write, creq_strobe); end
    cresp_ready = 1'b1; cresp_data = 64'h55; #1;
    n_tests++; if (iresp_ready !== 1'b1 || iresp_data !== 64'h55 || dresp_ready !== 1'b0) begin n_fail++; $display("FAIL both_i_resp got i=%b data=%h d=%b exp i=1 data=55 d=0", iresp_ready, iresp_data, dresp_ready); end
    $display("[TB] fetch 80000004 -> %h", 64'h55);
    tick(); cresp_ready = 1'b0; ireq_valid = 1'b0;
  endtask

  task automatic test_starvation();
    int exp_i[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int got_i;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0040;
    dreq_valid = 1'b1; dreq_addr = 64'h8000_2000; dreq_write = 1'b0; dreq_size = 3'd3;
    for (int g = 0; g < 10; g++) begin
      tick(); #1;
      got_i = (creq_addr == 64'h8000_0040) ? 1 : 0;
      n_tests++; if (got_i != exp_i[g]) begin n_fail++; $display("FAIL starve_grant%0d got_i=%0d exp_i=%0d", g, got_i, exp_i[g]); end
      cresp_ready = 1'b1; cresp_data = 64'(g); #1;
      n_tests++; if (iresp_ready !== exp_i[g][0] || dresp_ready !== !exp_i[g][0]) begin n_fail++; $display("FAIL starve_resp%0d got i=%b d=%b exp_i=%0d", g, iresp_ready, dresp_ready, exp_i[g]); end
      $display("[TB] grant %0d -> %s", g, got_i ? "I" : "D");
      tick(); cresp_ready = 1'b0;
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0;
  endtask

  task automatic test_flush();
    int pulses = 0;
    ireq_valid = 1'b1; ireq_addr = 64'h8000_0100;
    tick(); ireq_valid = 1'b0; #1;
    n_tests++; if (creq_valid !== 1'b1 || creq_addr !== 64'h8000_0100) begin n_fail++; $display("FAIL flush_grant got v=%b addr=%h exp v=1 addr=0000000080000100", creq_valid, creq_addr); end
    for (int w = 0; w < 3; w++) begin
      if (iresp_ready) pulses++;
      tick(); #1;
    end
    cresp_ready = 1'b1; cresp_data = 64'hBAD; #1;
    if (iresp_ready) pulses++;
    n_tests++; if (creq_valid !== 1'b1) begin n_fail++; $display("FAIL flush_held got=%b exp=1", creq_valid); end
    tick(); cresp_ready = 1'b0; #1;
    if (iresp_ready) pulses++;
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL flush_pulses got=%0d exp=0", pulses); end
    n_tests++; if (creq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%b exp=0", creq_valid); end
    $display("[TB] flushed fetch 80000100 discarded");
    dreq_valid = 1'b1; dreq_addr = 64'h8000_3000; dreq_write = 1'b0; dreq_size = 3'd2;
    tick(); #1;
    n_tests++; if (creq_valid !== 1'b1 || creq_addr !== 64'h8000_3000) begin n_fail++; $display("FAIL flush_next got v=%b addr=%h exp v=1 addr=0000000080003000", creq_valid, creq_addr); end
    cresp_ready = 1'b1; cresp_data = 64'h77; #1;
    n_tests++; if (dresp_ready !== 1'b1 || dresp_data !== 64'h77) begin n_fail++; $display("FAIL flush_next_resp got rdy=%b data=%h exp rdy=1 data=77", dresp_ready, dresp_data); end
    tick(); cresp_ready = 1'b0; dreq_valid = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    dreq_valid = 1'b1; dreq_addr = 64'h8000_4000; dreq_write = 1'b1;
    dreq_size = 3'd3; dreq_strobe = 8'h0F; dreq_data = 64'hAA;
    tick(); #1;
    n_tests++; if (creq_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got=%b exp=1", creq_valid); end
    #1 reset = 1'b1; #1;
    n_tests++; if (creq_valid !== 1'b0 || creq_addr !== 64'h0 || creq_strobe !== 8'h00 || creq_write !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs got v=%b addr=%h strb=%h wr=%b exp all 0", creq_valid, creq_addr, creq_strobe, creq_write); end
    cresp_ready = 1'b1; #1;
    n_tests++; if (dresp_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_resp got=%b exp=0", dresp_ready); end
    cresp_ready = 1'b0;
    tick(); reset = 1'b0; #1;
    n_tests++; if (creq_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got=%b exp=0", creq_valid); end
    $display("[TB] store 80004000 abandoned by reset");
    tick(); #1;
    n_tests++; if (creq_valid !== 1'b1 || creq_addr !== 64'h8000_4000 || creq_strobe !== 8'h0F) begin n_fail++; $display("FAIL rmid_retry got v=%b addr=%h strb=%h", creq_valid, creq_addr, creq_strobe); end
    cresp_ready = 1'b1; #1;
    n_tests++; if (dresp_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_retry_resp got=%b exp=1", dresp_ready); end
    $display("[TB] store 80004000 retried after reset");
    tick(); cresp_ready = 1'b0; dreq_valid = 1'b0; dreq_write = 1'b0;
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin ireq_valid = 1'b1; ireq_addr = 64'h8000_0000 + 64'(4 * k); end
      else begin dreq_valid = 1'b1; dreq_addr = 64'h8000_5000; dreq_write = 1'b0; dreq_size = 3'd3; end
      tick();
      tick(); cresp_ready = 1'b1;
      tick(); cresp_ready = 1'b0; ireq_valid = 1'b0; dreq_valid = 1'b0;
      $display("[TB] perf transaction %0d (%s)", k, (k < 3) ? "fetch" : "load");
    end
    #1;
    n_tests++; if (perf_icnt !== 32'd3) begin n_fail++; $display("FAIL perf_icnt got=%0d exp=3", perf_icnt); end
    n_tests++; if (perf_dcnt !== 32'd2) begin n_fail++; $display("FAIL perf_dcnt got=%0d exp=2", perf_dcnt); end
    n_tests++; if (perf_busy !== 32'd10) begin n_fail++; $display("FAIL perf_busy got=%0d exp=10", perf_busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_both_valid();
    test_starvation();
    test_flush();
    test_reset_mid_busy();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory port (cbus) between the fetch requester (ibus) and the memory-stage requester (dbus).
- Loads and stores from the memory stage have priority over fetch. A starvation counter guarantees that fetch makes forward progress.
- Sits between the pipeline front/memory stages and the cache/bus interconnect; one transaction is in flight at a time.

Parameters:
- MAX_STARVE, 4: consecutive dbus grants while ibus is pending, after which ibus is granted next.
- CNT_W, 32: width of the performance counters. Used only with MEM_ARB_PERF_EN.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request pending
- ireq_addr  in  64  fetch address; read-only, size fixed at 4 bytes
- iresp_ready  out  1  one-cycle pulse: fetch data valid
- iresp_data  out  64  fetch data; valid only while iresp_ready
- dreq_valid  in  1  memory-stage request pending
- dreq_addr  in  64  data address
- dreq_write  in  1  1 = store, 0 = load
- dreq_size  in  3  msize encoding (1/2/4/8 bytes)
- dreq_strobe  in  8  byte strobe for stores
- dreq_data  in  64  store data
- dresp_ready  out  1  one-cycle pulse: data transaction done
- dresp_data  out  64  load data; valid only while dresp_ready
- creq_valid  out  1  request to core bus
- creq_addr  out  64  registered address
- creq_write  out  1  registered write flag; 0 for ibus
- creq_size  out  3  registered size; MSIZE4 for ibus
- creq_strobe  out  8  registered strobe; 0 for ibus and loads
- creq_data  out  64  registered store data
- cresp_ready  in  1  core bus completion; single beat
- cresp_data  in  64  core bus read data

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset value IDLE.
- Reset values: all outputs 0; starve_cnt = 0.
- IDLE arbitration, evaluated each cycle. Winner is latched on the rising edge.
  - dreq_valid && !(ireq_valid && starve_cnt == MAX_STARVE) -> BUSY_D
  - else ireq_valid -> BUSY_I
  - else stay IDLE
- Grant latches addr/write/size/strobe/data into the creq_* registers. creq_valid = 1 from the cycle after the grant edge.
- creq_* are stable while BUSY_*; the arbiter ignores requester input changes after the grant.
- In BUSY_x with cresp_ready = 1 (cycle M):
  - the matching resp_ready is driven combinationally in cycle M, with resp_data = cresp_data;
  - next state is IDLE; creq_valid = 0 at M+1.
- Latency and throughput: minimum 2 cycles from request to response, with a zero-wait bus. At most one transaction per 2 cycles.
- Requester contract:
  - Hold valid and payload until the resp_ready pulse.
  - Deassert valid, or present a new request, in the cycle after the pulse.
  - The arbiter re-arbitrates in the IDLE cycle that follows.
- Fetch flush: if ireq_valid = 0 while in BUSY_I (jump/branch flush), the bus transaction still completes. On completion iresp_ready stays 0 and the data is discarded.
- dbus must never drop valid mid-transaction. Doing so is a requester bug; the arbiter still completes the transaction and pulses dresp_ready.
- starve_cnt updates:
  - increments on each BUSY_D grant while ireq_valid = 1;
  - clears on any BUSY_I grant;
  - saturates at MAX_STARVE.
- Simultaneous events:
  - both requests valid and starve_cnt < MAX_STARVE -> dbus wins;
  - both requests valid and starve_cnt == MAX_STARVE -> ibus wins, counter clears.
- Asynchronous reset during BUSY_*:
  - immediate return to IDLE, all outputs 0;
  - the in-flight transaction is abandoned; downstream is reset by the same signal.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined, adds three outputs, each CNT_W wide:
  - perf_icnt: count of completed ibus transactions, including discarded ones;
  - perf_dcnt: count of completed dbus transactions;
  - perf_busy: cycles spent in BUSY_*.
- Counters reset to 0 and wrap at 2^CNT_W.
- Without the macro, the ports and counter registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package `common` holds addr_t, word_t, strobe_t, msize_t (MSIZE1/2/4/8) and the cbus request/response structs.
- arb_state_t (IDLE/BUSY_I/BUSY_D) is local to the module.
- One natural sub-module, mem_arb_pick: combinational winner selection from (ireq_valid, dreq_valid, starve_cnt == MAX_STARVE).

Test Plan:
- Fetch only, bus ready 1 cycle after creq_valid, ireq_addr = 0x8000_0000:
  - creq_addr = 0x8000_0000, creq_size = MSIZE4, creq_write = 0;
  - iresp_ready pulses once, iresp_data = cresp_data = 0x13.
- Both valid at the same edge; dbus store 0x8000_1000 with strobe 0xFF:
  - dbus served first, dresp_ready pulse;
  - then ibus served, iresp_ready pulse.
- dreq_valid held high continuously with ireq_valid = 1, MAX_STARVE = 4:
  - grant sequence D,D,D,D,I,D,D,D,D,I.
- Fetch granted, ireq_valid dropped before a 3-cycle-delayed cresp_ready:
  - transaction completes; iresp_ready never pulses; FSM returns to IDLE.
- reset asserted mid-BUSY_D with cresp_ready = 0:
  - all outputs 0 immediately; IDLE after release; next request is serviced normally.
- With MEM_ARB_PERF_EN: 3 fetches and 2 loads, each with a 1-wait bus:
  - perf_icnt = 3, perf_dcnt = 2, perf_busy = 10.
